// File: rtl/ami_warb.sv
// Round-robin arbiter sharing one AXI write port (AW/W/B) among NR requesters.
// AW is granted and registered; W follows grant order via an order FIFO; B is routed by upper ID bits.
module ami_warb #(
  parameter int NR     = 4,
  parameter int AXI_DW = 128,
  parameter int AXI_AW = 32,
  parameter int AXI_IW = 8,
  parameter int AXI_LW = 8,
  parameter int AXI_SW = 3,
  parameter int OQ_D   = 4,
  localparam int PW    = $clog2(NR),
  localparam int RIW   = AXI_IW - PW,
  localparam int SB    = AXI_DW / 8
) (
  input  logic                   usr_clk,
  input  logic                   usr_reset_n,
  input  logic [NR*RIW-1:0]      s_awid,
  input  logic [NR*AXI_AW-1:0]   s_awaddr,
  input  logic [NR*AXI_LW-1:0]   s_awlen,
  input  logic [NR*AXI_SW-1:0]   s_awsize,
  input  logic [NR*2-1:0]        s_awburst,
  input  logic [NR-1:0]          s_awvalid,
  output logic [NR-1:0]          s_awready,
  input  logic [NR*AXI_DW-1:0]   s_wdata,
  input  logic [NR*SB-1:0]       s_wstrb,
  input  logic [NR-1:0]          s_wlast,
  input  logic [NR-1:0]          s_wvalid,
  output logic [NR-1:0]          s_wready,
  output logic [RIW-1:0]         s_bid,
  output logic [1:0]             s_bresp,
  output logic [NR-1:0]          s_bvalid,
  input  logic [NR-1:0]          s_bready,
  output logic [AXI_IW-1:0]      m_awid,
  output logic [AXI_AW-1:0]      m_awaddr,
  output logic [AXI_LW-1:0]      m_awlen,
  output logic [AXI_SW-1:0]      m_awsize,
  output logic [1:0]             m_awburst,
  output logic                   m_awvalid,
  input  logic                   m_awready,
  output logic [AXI_DW-1:0]      m_wdata,
  output logic [SB-1:0]          m_wstrb,
  output logic                   m_wlast,
  output logic                   m_wvalid,
  input  logic                   m_wready,
  input  logic [AXI_IW-1:0]      m_bid,
  input  logic [1:0]             m_bresp,
  input  logic                   m_bvalid,
  output logic                   m_bready
);

  // Handshakes: a transfer happens on any rising clock edge where valid and ready are both high;
  // valid never waits on ready, and payload stays stable while valid is high and ready is low.

  localparam int QW = $clog2(OQ_D);

  typedef enum logic {AW_IDLE = 1'b0, AW_BUSY = 1'b1} aw_state_e;

  aw_state_e         aw_state_q, aw_state_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [AXI_IW-1:0] m_awid_q, m_awid_d;
  logic [AXI_AW-1:0] m_awaddr_q, m_awaddr_d;
  logic [AXI_LW-1:0] m_awlen_q, m_awlen_d;
  logic [AXI_SW-1:0] m_awsize_q, m_awsize_d;
  logic [1:0]        m_awburst_q, m_awburst_d;
  logic              m_awvalid_q, m_awvalid_d;

  logic [PW-1:0]     oq_mem_q [OQ_D];
  logic [QW-1:0]     oq_wr_q, oq_wr_d, oq_rd_q, oq_rd_d;
  logic [QW:0]       oq_cnt_q, oq_cnt_d;

  logic              gnt_found, aw_go, oq_full, oq_empty, w_pop, b_legal;
  logic [PW-1:0]     gnt_idx, head_idx, b_idx;

  // Scan from the RR pointer upward with wrap; iterating downward lets the nearest requester win.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = NR - 1; k >= 0; k--) begin
      if (s_awvalid[(int'(rr_q) + k) % NR]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'((int'(rr_q) + k) % NR);
      end
    end
  end

  assign oq_full   = (oq_cnt_q == (QW+1)'(OQ_D));
  assign oq_empty  = (oq_cnt_q == '0);
  assign aw_go     = (aw_state_q == AW_IDLE) && gnt_found && !oq_full;
  assign s_awready = aw_go ? (NR'(1) << gnt_idx) : '0;

  always_comb begin
    aw_state_d  = aw_state_q;
    rr_d        = rr_q;
    win_d       = win_q;
    m_awid_d    = m_awid_q;
    m_awaddr_d  = m_awaddr_q;
    m_awlen_d   = m_awlen_q;
    m_awsize_d  = m_awsize_q;
    m_awburst_d = m_awburst_q;
    case (aw_state_q)
      AW_IDLE: begin
        if (aw_go) begin
          aw_state_d  = AW_BUSY;
          win_d       = gnt_idx;
          m_awid_d    = {gnt_idx, s_awid[gnt_idx*RIW +: RIW]};
          m_awaddr_d  = s_awaddr[gnt_idx*AXI_AW +: AXI_AW];
          m_awlen_d   = s_awlen[gnt_idx*AXI_LW +: AXI_LW];
          m_awsize_d  = s_awsize[gnt_idx*AXI_SW +: AXI_SW];
          m_awburst_d = s_awburst[gnt_idx*2 +: 2];
        end
      end
      AW_BUSY: begin
        if (m_awready) begin
          aw_state_d = AW_IDLE;
          rr_d       = (win_q == PW'(NR - 1)) ? '0 : win_q + 1'b1;
        end
      end
      default: aw_state_d = AW_IDLE;
    endcase
    m_awvalid_d = (aw_state_d == AW_BUSY);
  end

  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      aw_state_q  <= AW_IDLE;
      rr_q        <= '0;
      win_q       <= '0;
      m_awid_q    <= '0;
      m_awaddr_q  <= '0;
      m_awlen_q   <= '0;
      m_awsize_q  <= '0;
      m_awburst_q <= '0;
      m_awvalid_q <= 1'b0;
    end else begin
      aw_state_q  <= aw_state_d;
      rr_q        <= rr_d;
      win_q       <= win_d;
      m_awid_q    <= m_awid_d;
      m_awaddr_q  <= m_awaddr_d;
      m_awlen_q   <= m_awlen_d;
      m_awsize_q  <= m_awsize_d;
      m_awburst_q <= m_awburst_d;
      m_awvalid_q <= m_awvalid_d;
    end
  end

  assign m_awid    = m_awid_q;
  assign m_awaddr  = m_awaddr_q;
  assign m_awlen   = m_awlen_q;
  assign m_awsize  = m_awsize_q;
  assign m_awburst = m_awburst_q;
  assign m_awvalid = m_awvalid_q;

  // Order FIFO of granted requester indices; the head owns the W channel until its wlast.
  always_comb begin
    oq_wr_d  = aw_go ? oq_wr_q + 1'b1 : oq_wr_q;
    oq_rd_d  = w_pop ? oq_rd_q + 1'b1 : oq_rd_q;
    oq_cnt_d = oq_cnt_q;
    case ({aw_go, w_pop})
      2'b10:   oq_cnt_d = oq_cnt_q + 1'b1;
      2'b01:   oq_cnt_d = oq_cnt_q - 1'b1;
      default: oq_cnt_d = oq_cnt_q;
    endcase
  end

  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      oq_wr_q  <= '0;
      oq_rd_q  <= '0;
      oq_cnt_q <= '0;
      for (int i = 0; i < OQ_D; i++) oq_mem_q[i] <= '0;
    end else begin
      oq_wr_q  <= oq_wr_d;
      oq_rd_q  <= oq_rd_d;
      oq_cnt_q <= oq_cnt_d;
      if (aw_go) oq_mem_q[oq_wr_q] <= gnt_idx;
    end
  end

  assign head_idx = oq_mem_q[oq_rd_q];
  assign m_wdata  = s_wdata[head_idx*AXI_DW +: AXI_DW];
  assign m_wstrb  = s_wstrb[head_idx*SB +: SB];
  assign m_wlast  = s_wlast[head_idx];
  assign m_wvalid = !oq_empty && s_wvalid[head_idx];
  assign s_wready = oq_empty ? '0 : (NR'(m_wready) << head_idx);
  assign w_pop    = m_wvalid && m_wready && m_wlast;

  // An index beyond NR-1 is accepted and dropped so a stray response cannot stall the port.
  assign b_idx    = m_bid[AXI_IW-1:RIW];
  assign b_legal  = ({1'b0, b_idx} < (PW+1)'(NR));
  assign s_bvalid = b_legal ? (NR'(m_bvalid) << b_idx) : '0;
  assign m_bready = b_legal ? s_bready[b_idx] : 1'b1;
  assign s_bid    = m_bid[RIW-1:0];
  assign s_bresp  = m_bresp;

endmodule

// File: tb/tb_ami_warb.sv
// Directed and randomized bench for ami_warb against a transaction-level reference model
// (grant rotation, queue of granted owners, expected AW queue).
module tb_ami_warb;
  localparam int NR = 4, AXI_DW = 128, AXI_AW = 32, AXI_IW = 8, AXI_LW = 8, AXI_SW = 3, OQ_D = 4;
  localparam int PW = 2, RIW = 6, SB = AXI_DW / 8;

  typedef logic [127:0] cw_t;

  logic                   usr_clk = 1'b0;
  logic                   usr_reset_n;
  logic [NR*RIW-1:0]      s_awid;
  logic [NR*AXI_AW-1:0]   s_awaddr;
  logic [NR*AXI_LW-1:0]   s_awlen;
  logic [NR*AXI_SW-1:0]   s_awsize;
  logic [NR*2-1:0]        s_awburst;
  logic [NR-1:0]          s_awvalid, s_awready;
  logic [NR*AXI_DW-1:0]   s_wdata;
  logic [NR*SB-1:0]       s_wstrb;
  logic [NR-1:0]          s_wlast, s_wvalid, s_wready;
  logic [RIW-1:0]         s_bid;
  logic [1:0]             s_bresp;
  logic [NR-1:0]          s_bvalid, s_bready;
  logic [AXI_IW-1:0]      m_awid;
  logic [AXI_AW-1:0]      m_awaddr;
  logic [AXI_LW-1:0]      m_awlen;
  logic [AXI_SW-1:0]      m_awsize;
  logic [1:0]             m_awburst;
  logic                   m_awvalid, m_awready;
  logic [AXI_DW-1:0]      m_wdata;
  logic [SB-1:0]          m_wstrb;
  logic                   m_wlast, m_wvalid, m_wready;
  logic [AXI_IW-1:0]      m_bid;
  logic [1:0]             m_bresp;
  logic                   m_bvalid, m_bready;

  int checks = 0;
  int failures = 0;

  ami_warb #(.NR(NR), .AXI_DW(AXI_DW), .AXI_AW(AXI_AW), .AXI_IW(AXI_IW), .AXI_LW(AXI_LW),
             .AXI_SW(AXI_SW), .OQ_D(OQ_D)) dut (
    .usr_clk(usr_clk), .usr_reset_n(usr_reset_n),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
    .s_bready(s_bready), .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready)
  );

  // Clock / reset
  always #5 usr_clk = ~usr_clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic chk(input string tag, input cw_t obs, input cw_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge usr_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge usr_clk);
  endtask

  task automatic idle_inputs();
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = '0;
    s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    usr_reset_n = 1'b0;
    repeat (2) @(posedge usr_clk);
    #1 usr_reset_n = 1'b1;
  endtask

  task automatic set_aw(input int i, input logic [RIW-1:0] id, input logic [AXI_AW-1:0] addr,
                        input logic [AXI_LW-1:0] len);
    s_awid[i*RIW +: RIW]         = id;
    s_awaddr[i*AXI_AW +: AXI_AW] = addr;
    s_awlen[i*AXI_LW +: AXI_LW]  = len;
    s_awsize[i*AXI_SW +: AXI_SW] = 3'd4;
    s_awburst[i*2 +: 2]          = 2'b01;
  endtask

  function automatic logic [AXI_DW-1:0] rnd_data();
    logic [AXI_DW-1:0] d;
    for (int j = 0; j < AXI_DW / 32; j++) d[j*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic int oh2i(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Scoreboard / reference model state
  logic [AXI_IW+AXI_AW-1:0] exp_q[$];
  int                       own_q[$];
  int                       m_rr, m_win;
  bit                       m_busy;

  logic [AXI_AW-1:0] a2;
  logic [AXI_DW-1:0] d0, d1, beat [4];
  int gnt_who[$], gnt_cyc[$];
  int g;

  initial begin
    idle_inputs();
    usr_reset_n = 1'b0;

    // Reset state
    do_reset();
    mid();
    chk("rst_awvalid", cw_t'(m_awvalid), cw_t'(0));
    chk("rst_awid", cw_t'(m_awid), cw_t'(0));
    chk("rst_awaddr", cw_t'(m_awaddr), cw_t'(0));
    chk("rst_awlen", cw_t'(m_awlen), cw_t'(0));
    chk("rst_awready", cw_t'(s_awready), cw_t'(0));
    chk("rst_wready", cw_t'(s_wready), cw_t'(0));
    chk("rst_wvalid", cw_t'(m_wvalid), cw_t'(0));

    // Single requester 2: id 5, len 3, four beats
    cyc();
    a2 = $urandom;
    set_aw(2, 6'd5, a2, 8'd3);
    s_awvalid = 4'b0100;
    mid();
    chk("t1_awready", cw_t'(s_awready), cw_t'(4'b0100));
    chk("t1_awvalid_pre", cw_t'(m_awvalid), cw_t'(0));
    cyc();
    s_awvalid = '0;
    m_awready = 1'b1;
    mid();
    chk("t1_awvalid", cw_t'(m_awvalid), cw_t'(1));
    chk("t1_awid", cw_t'(m_awid), cw_t'(8'h85));
    chk("t1_awaddr", cw_t'(m_awaddr), cw_t'(a2));
    chk("t1_awlen", cw_t'(m_awlen), cw_t'(3));
    chk("t1_awsize", cw_t'(m_awsize), cw_t'(4));
    chk("t1_busy_noready", cw_t'(s_awready), cw_t'(0));
    cyc();
    m_awready = 1'b0;
    mid();
    chk("t1_awvalid_fall", cw_t'(m_awvalid), cw_t'(0));
    for (int b = 0; b < 4; b++) begin
      cyc();
      s_wdata = {rnd_data(), rnd_data(), rnd_data(), rnd_data()};
      beat[b] = rnd_data();
      s_wdata[2*AXI_DW +: AXI_DW] = beat[b];
      s_wvalid = 4'b0100;
      s_wlast = (b == 3) ? 4'b0100 : 4'b1011;
      m_wready = 1'b1;
      mid();
      chk("t1_wvalid", cw_t'(m_wvalid), cw_t'(1));
      chk("t1_wdata", cw_t'(m_wdata), cw_t'(beat[b]));
      chk("t1_wlast", cw_t'(m_wlast), cw_t'(b == 3));
      chk("t1_wready", cw_t'(s_wready), cw_t'(4'b0100));
    end
    cyc();
    s_wlast = '0;
    mid();
    chk("t1_empty_wvalid", cw_t'(m_wvalid), cw_t'(0));
    chk("t1_empty_wready", cw_t'(s_wready), cw_t'(0));

    // Fairness: all four requesting, single-beat bursts drain every cycle
    do_reset();
    s_awvalid = 4'b1111;
    m_awready = 1'b1;
    s_wvalid = 4'b1111;
    s_wlast = 4'b1111;
    m_wready = 1'b1;
    gnt_who.delete();
    gnt_cyc.delete();
    for (int c = 0; c < 10; c++) begin
      mid();
      if (s_awready != '0) begin
        gnt_who.push_back(oh2i(s_awready));
        gnt_cyc.push_back(c);
        chk("rr_onehot", cw_t'($countones(s_awready)), cw_t'(1));
      end
      cyc();
    end
    chk("rr_count", cw_t'(gnt_who.size()), cw_t'(5));
    for (int k = 0; k < 5 && k < gnt_who.size(); k++) begin
      chk("rr_order", cw_t'(gnt_who[k]), cw_t'(k % NR));
      chk("rr_cycle", cw_t'(gnt_cyc[k]), cw_t'(2 * k));
    end

    // W-before-AW: requester 1 data waits until requester 0 finishes
    do_reset();
    d0 = rnd_data();
    d1 = rnd_data();
    s_wdata[0 +: AXI_DW] = d0;
    s_wdata[AXI_DW +: AXI_DW] = d1;
    s_awvalid = 4'b0001;
    s_wvalid = 4'b0010;
    s_wlast = 4'b0011;
    m_wready = 1'b1;
    mid();
    chk("wba_awready0", cw_t'(s_awready), cw_t'(4'b0001));
    chk("wba_wready_empty", cw_t'(s_wready), cw_t'(0));
    chk("wba_wvalid_empty", cw_t'(m_wvalid), cw_t'(0));
    cyc();
    s_awvalid = 4'b0010;
    m_awready = 1'b1;
    mid();
    chk("wba_busy", cw_t'(s_awready), cw_t'(0));
    chk("wba_head0", cw_t'(s_wready), cw_t'(4'b0001));
    chk("wba_blocked", cw_t'(m_wvalid), cw_t'(0));
    cyc();
    m_awready = 1'b0;
    mid();
    chk("wba_awready1", cw_t'(s_awready), cw_t'(4'b0010));
    chk("wba_head0b", cw_t'(s_wready), cw_t'(4'b0001));
    cyc();
    s_awvalid = '0;
    s_wvalid = 4'b0011;
    mid();
    chk("wba_w0_valid", cw_t'(m_wvalid), cw_t'(1));
    chk("wba_w0_data", cw_t'(m_wdata), cw_t'(d0));
    cyc();
    s_wvalid = 4'b0010;
    mid();
    chk("wba_head1", cw_t'(s_wready), cw_t'(4'b0010));
    chk("wba_w1_data", cw_t'(m_wdata), cw_t'(d1));
    chk("wba_w1_last", cw_t'(m_wlast), cw_t'(1));
    cyc();
    s_wvalid = '0;
    mid();
    chk("wba_drained", cw_t'(s_wready), cw_t'(0));

    // Order FIFO full blocks the fifth grant until one wlast retires
    do_reset();
    s_awvalid = 4'b0001;
    m_awready = 1'b1;
    g = 0;
    for (int c = 0; c < 12; c++) begin
      mid();
      if (s_awready != '0) g++;
      cyc();
    end
    chk("full_grants", cw_t'(g), cw_t'(OQ_D));
    mid();
    chk("full_blocked", cw_t'(s_awready), cw_t'(0));
    cyc();
    s_wvalid = 4'b0001;
    s_wlast = 4'b0001;
    m_wready = 1'b1;
    mid();
    chk("full_samecyc", cw_t'(s_awready), cw_t'(0));
    chk("full_wready", cw_t'(s_wready), cw_t'(4'b0001));
    cyc();
    s_wvalid = '0;
    m_wready = 1'b0;
    mid();
    chk("full_regrant", cw_t'(s_awready), cw_t'(4'b0001));

    // B routing
    cyc();
    idle_inputs();
    m_bid = 8'hC7;
    m_bresp = 2'b10;
    m_bvalid = 1'b1;
    #1;
    chk("b_valid", cw_t'(s_bvalid), cw_t'(4'b1000));
    chk("b_id", cw_t'(s_bid), cw_t'(6'h07));
    chk("b_resp", cw_t'(s_bresp), cw_t'(2'b10));
    chk("b_stall", cw_t'(m_bready), cw_t'(0));
    s_bready = 4'b0111;
    #1;
    chk("b_stall_other", cw_t'(m_bready), cw_t'(0));
    s_bready = 4'b1000;
    #1;
    chk("b_ready", cw_t'(m_bready), cw_t'(1));
    for (int t = 0; t < 16; t++) begin
      m_bid = AXI_IW'($urandom);
      m_bresp = 2'($urandom);
      m_bvalid = 1'($urandom);
      s_bready = NR'($urandom);
      #1;
      chk("b_rnd_valid", cw_t'(s_bvalid), cw_t'(m_bvalid ? (1 << (m_bid / 64)) : 0));
      chk("b_rnd_ready", cw_t'(m_bready), cw_t'(s_bready[m_bid / 64]));
      chk("b_rnd_id", cw_t'(s_bid), cw_t'(m_bid % 64));
    end

    // Reset during a burst: AW stuck busy, two of four beats sent
    do_reset();
    set_aw(1, 6'd9, 32'h1000, 8'd3);
    s_awvalid = 4'b0010;
    cyc();
    s_awvalid = '0;
    s_wvalid = 4'b0010;
    m_wready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      mid();
      chk("mr_beat", cw_t'(m_wvalid), cw_t'(1));
      cyc();
    end
    mid();
    chk("mr_busy", cw_t'(m_awvalid), cw_t'(1));
    #1 usr_reset_n = 1'b0;
    #1;
    chk("mr_awvalid", cw_t'(m_awvalid), cw_t'(0));
    chk("mr_wvalid", cw_t'(m_wvalid), cw_t'(0));
    chk("mr_wready", cw_t'(s_wready), cw_t'(0));
    cyc();
    usr_reset_n = 1'b1;
    s_awvalid = 4'b1111;
    mid();
    chk("mr_rr0", cw_t'(s_awready), cw_t'(4'b0001));
    chk("mr_fifo_empty", cw_t'(m_wvalid), cw_t'(0));

    // Randomized traffic against the reference model
    do_reset();
    exp_q.delete();
    own_q.delete();
    m_rr = 0;
    m_win = 0;
    m_busy = 1'b0;
    for (int c = 0; c < 400; c++) begin
      int win;
      bit grant, pop;
      logic [NR-1:0] exp_awr, exp_wr;
      s_awvalid = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        set_aw(i, RIW'($urandom), $urandom, AXI_LW'($urandom_range(0, 3)));
        s_wdata[i*AXI_DW +: AXI_DW] = rnd_data();
      end
      s_wvalid = NR'($urandom);
      s_wlast = NR'($urandom);
      m_awready = 1'($urandom_range(0, 1));
      m_wready = 1'($urandom_range(0, 1));
      mid();
      win = -1;
      for (int k = 0; k < NR && win < 0; k++) if (s_awvalid[(m_rr + k) % NR]) win = (m_rr + k) % NR;
      grant = !m_busy && (win >= 0) && (own_q.size() < OQ_D);
      exp_awr = grant ? NR'(1 << win) : '0;
      chk("rnd_awready", cw_t'(s_awready), cw_t'(exp_awr));
      chk("rnd_awvalid", cw_t'(m_awvalid), cw_t'(m_busy));
      if (m_busy && m_awready && exp_q.size() > 0)
        chk("rnd_aw", cw_t'({m_awid, m_awaddr}), cw_t'(exp_q.pop_front()));
      pop = 1'b0;
      if (own_q.size() > 0) begin
        exp_wr = NR'(m_wready) << own_q[0];
        chk("rnd_wready", cw_t'(s_wready), cw_t'(exp_wr));
        chk("rnd_wvalid", cw_t'(m_wvalid), cw_t'(s_wvalid[own_q[0]]));
        if (s_wvalid[own_q[0]]) begin
          chk("rnd_wdata", cw_t'(m_wdata), cw_t'(s_wdata[own_q[0]*AXI_DW +: AXI_DW]));
          chk("rnd_wlast", cw_t'(m_wlast), cw_t'(s_wlast[own_q[0]]));
        end
        pop = s_wvalid[own_q[0]] && m_wready && s_wlast[own_q[0]];
      end else begin
        chk("rnd_wready_empty", cw_t'(s_wready), cw_t'(0));
        chk("rnd_wvalid_empty", cw_t'(m_wvalid), cw_t'(0));
      end
      if (pop) void'(own_q.pop_front());
      if (grant) begin
        exp_q.push_back({PW'(win), s_awid[win*RIW +: RIW], s_awaddr[win*AXI_AW +: AXI_AW]});
        own_q.push_back(win);
        m_busy = 1'b1;
        m_win = win;
      end else if (m_busy && m_awready) begin
        m_busy = 1'b0;
        m_rr = (m_win + 1) % NR;
      end
      cyc();
    end

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ami_warb.md
Name: ami_warb

Overview:
- Round-robin write-path arbiter that lets NR user requesters share one ami user write port (AW/W/B).
- Sits between the requester blocks and ami's usr_aw*/usr_w*/usr_b* ports, in the usr_clk domain.
- AW requests are arbitrated and registered. W beats follow AW grant order through an order FIFO. B responses return to requesters by an index carried in the upper ID bits.

Parameters:
- NR, 4, number of requesters (2..8).
- AXI_DW, 128, data width.
- AXI_AW, 32, address width.
- AXI_IW, 8, downstream ID width; requester ID width RIW = AXI_IW - $clog2(NR).
- AXI_LW, 8, length width.
- AXI_SW, 3, size width.
- OQ_D, 4, order FIFO depth (power of 2), i.e. max AW bursts granted but not yet fully written.

Ports:
- usr_clk in 1: clock.
- usr_reset_n in 1: asynchronous active-low reset.
- s_awid in NR*RIW: requester AW IDs, requester i at slice i.
- s_awaddr in NR*AXI_AW: requester addresses.
- s_awlen in NR*AXI_LW: requester burst lengths.
- s_awsize in NR*AXI_SW: requester burst sizes.
- s_awburst in NR*2: requester burst types.
- s_awvalid in NR: requester AW valid.
- s_awready out NR: requester AW ready.
- s_wdata in NR*AXI_DW: requester write data.
- s_wstrb in NR*AXI_DW/8: requester write strobes.
- s_wlast in NR: requester last beat.
- s_wvalid in NR: requester W valid.
- s_wready out NR: requester W ready.
- s_bid out RIW: response ID, shared by all requesters.
- s_bresp out 2: response code, shared by all requesters.
- s_bvalid out NR: response valid, one per requester.
- s_bready in NR: response ready, one per requester.
- m_awid out AXI_IW: downstream AW ID.
- m_awaddr out AXI_AW: downstream address.
- m_awlen out AXI_LW: downstream length.
- m_awsize out AXI_SW: downstream size.
- m_awburst out 2: downstream burst type.
- m_awvalid out 1: downstream AW valid.
- m_awready in 1: downstream AW ready.
- m_wdata out AXI_DW: downstream write data.
- m_wstrb out AXI_DW/8: downstream write strobes.
- m_wlast out 1: downstream last beat.
- m_wvalid out 1: downstream W valid.
- m_wready in 1: downstream W ready.
- m_bid in AXI_IW: downstream response ID.
- m_bresp in 2: downstream response code.
- m_bvalid in 1: downstream response valid.
- m_bready out 1: downstream response ready.

Behaviour:
- Reset (async, usr_reset_n=0):
  - Outputs: m_awvalid=0, all m_aw* fields=0, s_awready=0.
  - State: FSM in AW_IDLE, RR pointer=0, order FIFO empty.
  - Reset aborts any burst in flight; no recovery is attempted.
- AW FSM, AW_IDLE:
  - Condition: any s_awvalid and order FIFO not full.
  - Winner: first requester with s_awvalid set, scanning from the RR pointer upward with wrap.
  - Same cycle: s_awready[winner]=1 (one-hot, combinational); winner's fields are registered into m_aw*; m_awid={winner index, s_awid slice}; winner index is pushed into the order FIFO.
  - Next state: AW_BUSY.
  - AW latency from request to m_awvalid is 1 cycle.
- AW FSM, AW_BUSY:
  - m_awvalid=1; m_aw* held stable.
  - On m_awready: m_awvalid falls next cycle, RR pointer = winner+1 mod NR, return to AW_IDLE.
  - No new grant while in AW_BUSY. Maximum AW throughput is 1 burst per 2 cycles.
- W routing (combinational, zero latency):
  - When the order FIFO is non-empty, head index h selects the source: m_w* = s_w*[h], m_wvalid = s_wvalid[h], s_wready[h] = m_wready.
  - All other s_wready bits are 0.
  - When the order FIFO is empty: m_wvalid=0, all s_wready=0.
  - Pop on m_wvalid & m_wready & m_wlast.
  - A requester's W beats are therefore blocked until its AW is granted (W-before-AW is stalled, not lost).
- Order FIFO:
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Full blocks new AW grants only; W routing continues.
  - Pointers are $clog2(OQ_D) bits and wrap naturally.
- B routing (combinational):
  - Decode idx = m_bid[AXI_IW-1:RIW].
  - s_bvalid[idx] = m_bvalid, other s_bvalid bits 0.
  - m_bready = s_bready[idx].
  - s_bid = m_bid[RIW-1:0], s_bresp = m_bresp.
  - idx >= NR (illegal) drives m_bready=1 so the response is dropped and the interface does not hang.
- Arbitration fairness: a continuously requesting requester waits at most NR-1 grants.

Test Plan:
- Single requester 2 issues AW with id=5, len=3, then 4 beats -> m_awid={2'd2,6'd5}; m_awvalid 1 cycle after s_awready; 4 W beats pass through with m_wlast on beat 4; FIFO returns to empty.
- All 4 requesters hold s_awvalid, m_awready=1 -> grant order 0,1,2,3,0; one grant every 2 cycles.
- W-before-AW: requester 1 asserts s_wvalid before its AW; requester 0 is granted first -> s_wready[1]=0 until requester 0's wlast pops and head becomes 1.
- OQ_D=4: 4 AWs granted, m_wready=0 -> 5th s_awvalid gets no s_awready; one wlast handshake -> 5th granted next cycle.
- m_bid=8'hC7 with NR=4 -> s_bvalid[3]=1, s_bid=6'h07; s_bready[3]=0 stalls m_bready.
- Reset asserted mid-burst (AW_BUSY, 2 of 4 beats sent) -> m_awvalid=0 and m_wvalid=0 immediately; FIFO empty; RR pointer 0 after release.
